router_pkt_tx: RTL

- Packet transmitter and traffic generator that drives the input side of the router 1x3.
- Produces a header byte, then N generated payload bytes, then a parity byte, on data_in/pkt_valid.
- Obeys the router's busy back-pressure and samples the router's err flag after each packet.
- Used as the packet source in block-level and top-level environments, and as an on-chip self-test source.

---
 rtl/router_pkt_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet transmitter / traffic generator for the router 1x3 input side.
// Sends a header byte {pkt_len, dest_addr}, pkt_len pattern bytes (incrementing or
// 8-bit Fibonacci LFSR), then the XOR parity byte, honouring busy back-pressure.
// After the parity byte it idles GAP_CYCLES cycles, watching err, then pulses done.
// Optional macro ROUTER_PKT_TX_PARITY_CORRUPT_EN adds a 'corrupt' input that flips
// bit 0 of the transmitted parity byte for error injection.
module router_pkt_tx #(
    parameter int GAP_CYCLES  = 2,
    parameter int STALL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  dest_addr,
    input  logic [5:0]  pkt_len,
    input  logic [7:0]  seed,
    input  logic        pat_mode,
    input  logic        busy,
    input  logic        err,
`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    input  logic        corrupt,
`endif
    output logic [7:0]  data_in,
    output logic        pkt_valid,
    output logic        active,
    output logic        done,
    output logic        cfg_err,
    output logic        err_seen,
    output logic        stall_flag,
    output logic [15:0] pkt_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_addr;
    logic [5:0]  r_len;
    logic        r_mode;
    logic [7:0]  r_pat;
    logic [5:0]  r_remaining;
    logic [7:0]  r_parity;
    logic [3:0]  r_gap_cnt;
    logic [15:0] r_stall_cnt;
    logic        r_done;
    logic        r_cfg_err;
    logic        r_err_seen;
    logic        r_stall_flag;
    logic [15:0] r_pkt_count;
    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_cfg_ok;
    logic        w_sending;
    logic [7:0]  w_lfsr_next;
    logic [7:0]  w_pat_next;
    logic [7:0]  w_corrupt_mask;

    assign w_cfg_ok    = (dest_addr != 2'd3) && (pkt_len != 6'd0);
    assign w_sending   = (r_state == S_HEADER) || (r_state == S_PAYLOAD) || (r_state == S_PARITY);
    // Taps x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3, shifted in at bit 0.
    assign w_lfsr_next = {r_pat[6:0], r_pat[7] ^ r_pat[5] ^ r_pat[4] ^ r_pat[3]};
    assign w_pat_next  = r_mode ? w_lfsr_next : (r_pat + 8'd1);

`ifdef ROUTER_PKT_TX_PARITY_CORRUPT_EN
    logic r_corrupt;

    // Capture the error-injection request alongside the packet configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_corrupt <= 1'b0;
        end else if (r_state == S_IDLE && start && w_cfg_ok) begin
            r_corrupt <= corrupt;
        end
    end

    assign w_corrupt_mask = {7'd0, r_corrupt};
`else
    assign w_corrupt_mask = 8'h00;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic and the byte presented to the router; a byte only moves on when busy is low.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        w_next_state = r_state;
        w_data       = 8'h00;
        w_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_cfg_ok) w_next_state = S_HEADER;
            end
            S_HEADER: begin
                w_data  = {r_len, r_addr};
                w_valid = 1'b1;
                if (!busy) w_next_state = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                w_data  = r_pat;
                w_valid = 1'b1;
                if (!busy && r_remaining == 6'd1) w_next_state = S_PARITY;
            end
            S_PARITY: begin
                w_data = r_parity ^ w_corrupt_mask;
                if (!busy) w_next_state = S_PARITY == r_state ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (r_gap_cnt == 4'd0) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Packet datapath: config latch, pattern, parity accumulation, gap timing and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= 2'd0;
            r_len        <= 6'd0;
            r_mode       <= 1'b0;
            r_pat        <= 8'h00;
            r_remaining  <= 6'd0;
            r_parity     <= 8'h00;
            r_gap_cnt    <= 4'd0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_err_seen   <= 1'b0;
            r_pkt_count  <= 16'd0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_cfg_ok) begin
                        r_addr      <= dest_addr;
                        r_len       <= pkt_len;
                        r_mode      <= pat_mode;
                        // An all-zero LFSR would lock up, so seed 0 becomes 1 in LFSR mode.
                        r_pat       <= (pat_mode && seed == 8'h00) ? 8'h01 : seed;
                        r_remaining <= pkt_len;
                        r_parity    <= {pkt_len, dest_addr};
                        r_err_seen  <= 1'b0;
                    end else if (start) begin
                        r_cfg_err <= 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        r_parity    <= r_parity ^ r_pat;
                        r_pat       <= w_pat_next;
                        r_remaining <= r_remaining - 6'd1;
                    end
                end
                S_PARITY: begin
                    if (!busy) r_gap_cnt <= 4'(GAP_CYCLES - 1);
                end
                S_GAP: begin
                    if (err) r_err_seen <= 1'b1;
                    if (r_gap_cnt == 4'd0) begin
                        r_done      <= 1'b1;
                        r_pkt_count <= r_pkt_count + 16'd1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Consecutive-busy watchdog; the flag is sticky until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= 16'd0;
            r_stall_flag <= 1'b0;
        end else if (r_state == S_IDLE && start && w_cfg_ok) begin
            r_stall_cnt  <= 16'd0;
            r_stall_flag <= 1'b0;
        end else if (w_sending && busy) begin
            if (r_stall_cnt == 16'(STALL_LIMIT - 1)) r_stall_flag <= 1'b1;
            if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        end else begin
            r_stall_cnt <= 16'd0;
        end
    end

    assign data_in    = w_data;
    assign pkt_valid  = w_valid;
    assign active     = (r_state != S_IDLE);
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;
    assign err_seen   = r_err_seen;
    assign stall_flag = r_stall_flag;
    assign pkt_count  = r_pkt_count;

endmodule
